data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Slave end of the CPU data-memory interface. It consumes data_addr/data_wdata/data_we and returns data_rdata.
- Integrates three things behind one address decoder:
  - word RAM with byte-lane writes;
  - free-running cycle counter;
  - console byte FIFO plus a sticky test-exit register.
- Sits beside the CPU in SoC and simulation tops. Replaces ad-hoc memory models and gives programs a halt/pass/fail mechanism.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; power of 2.
- CON_DEPTH, 16, console FIFO depth in bytes; power of 2, at least 2.
- MMIO_BASE, 32'h8000_0000, base byte address of the MMIO register block.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset (reset while 0).
- data_addr_i  input  32  byte address from CPU.
- data_wdata_i  input  32  store data.
- data_we_i  input  4  byte-lane write enables; bit n covers bits [8n+7:8n].
- data_rdata_o  output  32  combinational read data for data_addr_i.
- con_valid_o  output  1  FIFO non-empty.
- con_data_o  output  8  FIFO head byte; valid when con_valid_o=1.
- con_ready_i  input  1  sink accepts head byte.
- halt_o  output  1  sticky; program wrote EXIT.
- pass_o  output  1  sticky; halt with exit code 0.
- fail_o  output  1  sticky; halt with non-zero exit code.
- exit_code_o  output  8  captured exit code.

Behaviour:
- Address decode: bits [1:0] are ignored everywhere, so accesses are word-aligned.
  - RAM hit: data_addr_i < RAM_WORDS*4. Index is addr[log2(RAM_WORDS)+1:2].
  - MMIO hit: addr[31:4] == MMIO_BASE[31:4]. Offset is addr[3:2].
  - Any other address: reads return 0; writes are ignored.
- Reads:
  - Purely combinational, zero latency, no side effects.
  - A same-cycle write is not forwarded: the read shows the old value, and the new value is visible the next cycle.
- RAM:
  - Each enabled byte lane is written at posedge. Disabled lanes keep their value.
  - Contents are not cleared by reset. Power-up value is 0 in simulation.
- MMIO offset 0, CYCLE (read-only): 32-bit counter.
  - 0 in reset; increments every cycle after reset release.
  - Wraps 0xFFFF_FFFF -> 0.
  - Writes are ignored.
- MMIO offset 1, CON_TX (write-only):
  - A write with data_we_i[0]=1 pushes data_wdata_i[7:0]. Other lanes are ignored.
  - Reads return 0.
- MMIO offset 2, CON_STAT (read-only):
  - bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count.
  - All other bits read 0.
- MMIO offset 3, EXIT:
  - A write with data_we_i[0]=1 while halt_o=0 sets halt_o=1 and exit_code_o=wdata[7:0].
  - pass_o = (wdata[7:0]==0); fail_o = its inverse.
  - First write wins; later writes are ignored until reset.
  - Reads return {23'b0, halt_o, exit_code_o}.
- FIFO:
  - Pop occurs when con_valid_o & con_ready_i.
  - Push is accepted iff count < CON_DEPTH at the start of the cycle.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - Push while full is dropped and sets overflow, even if a pop happens in the same cycle. The byte is lost.
  - con_valid_o = (count != 0). con_data_o = mem[rd_ptr].
  - Pointers wrap modulo CON_DEPTH.
  - con_data_o is undefined when empty.
- halt_o does not gate anything. RAM, FIFO and counter keep operating after halt.
- Reset (asynchronous assert, synchronous release):
  - CYCLE=0, count=0, pointers=0, overflow=0.
  - halt_o=0, pass_o=0, fail_o=0, exit_code_o=0, con_valid_o=0.
  - Reset mid-operation discards FIFO contents and status immediately. RAM is retained.

Test Plan:
- RAM byte lanes: write 0x11223344 to 0x100 with we=4'hF, then 0xAABBCCDD with we=4'b0101 -> read 0x100 returns 0x11BB33DD. Read 0x102 also returns 0x11BB33DD.
- Cycle counter: release reset, wait 10 cycles, read MMIO_BASE -> 10 (±0 by defined timing). Force counter to 0xFFFF_FFFF -> next cycle reads 0.
- Console FIFO: push 0x48, 0x69 with con_ready_i=0 -> CON_STAT=0x0000_0200. Raise ready -> con_data_o 0x48 then 0x69, then con_valid_o=0 and CON_STAT=0x0000_0002.
- Overflow: push 17 bytes with ready=0 -> CON_STAT bits show full=1, overflow=1, count=16. 17th byte absent when drained. Push and pop in the same cycle at count 3 -> count stays 3.
- Exit: write 0 to MMIO_BASE+0xC -> halt_o=1, pass_o=1, fail_o=0. A second write of 5 leaves exit_code_o=0. After reset, write 5 -> fail_o=1, exit_code_o=5.
- Async reset mid-run: drop rst between clock edges with FIFO count 4 -> con_valid_o=0 and counter 0 immediately. RAM word at 0x100 is unchanged after release. Unmapped address 0x4000 reads 0.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-memory slave: word RAM, free-running cycle counter, console byte FIFO
// and a sticky test-exit register behind one word-aligned address decoder.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned CON_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        halt_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic [7:0]  exit_code_o
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CON_AW = $clog2(CON_DEPTH);
  localparam int unsigned CNT_W  = CON_AW + 1;

  localparam logic [1:0] OFF_CYCLE    = 2'd0;
  localparam logic [1:0] OFF_CON_TX   = 2'd1;
  localparam logic [1:0] OFF_CON_STAT = 2'd2;
  localparam logic [1:0] OFF_EXIT     = 2'd3;

  logic [31:0]       ram [RAM_WORDS];
  logic [7:0]        con_mem [CON_DEPTH];
  logic [RAM_AW-1:0] ram_idx_c;
  logic              ram_hit_c;
  logic              mmio_hit_c;
  logic [1:0]        mmio_off_c;

  logic [31:0]       cycle_q;
  logic [CON_AW-1:0] wr_ptr_q;
  logic [CON_AW-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              push_req_c;
  logic              push_ok_c;
  logic              pop_c;
  logic              exit_wr_c;

  // Address decode; the low two address bits never matter.
  assign ram_hit_c  = data_addr_i < 32'(RAM_WORDS * 4);
  assign ram_idx_c  = data_addr_i[RAM_AW+1:2];
  assign mmio_hit_c = data_addr_i[31:4] == MMIO_BASE[31:4];
  assign mmio_off_c = data_addr_i[3:2];

  // FIFO handshake; a push into a full FIFO is dropped even if a pop frees a slot.
  assign fifo_full_c  = count_q == CNT_W'(CON_DEPTH);
  assign fifo_empty_c = count_q == '0;
  assign push_req_c   = mmio_hit_c && (mmio_off_c == OFF_CON_TX) && data_we_i[0];
  assign push_ok_c    = push_req_c && !fifo_full_c;
  assign pop_c        = !fifo_empty_c && con_ready_i;
  assign exit_wr_c    = mmio_hit_c && (mmio_off_c == OFF_EXIT) && data_we_i[0];

  assign con_valid_o = !fifo_empty_c;
  assign con_data_o  = con_mem[rd_ptr_q];

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_hit_c) begin
      for (int b = 0; b < 4; b++) begin
        if (data_we_i[b]) ram[ram_idx_c][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Console FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_c) con_mem[wr_ptr_q] <= data_wdata_i[7:0];
  end

  // Console FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + CON_AW'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + CON_AW'(1);
      count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      if (push_req_c && fifo_full_c) overflow_q <= 1'b1;
    end
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_q <= '0;
    else      cycle_q <= cycle_q + 32'd1;
  end

  // Test-exit register: first EXIT write after reset wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      exit_code_o <= '0;
    end else if (exit_wr_c && !halt_o) begin
      halt_o      <= 1'b1;
      pass_o      <= data_wdata_i[7:0] == 8'd0;
      fail_o      <= data_wdata_i[7:0] != 8'd0;
      exit_code_o <= data_wdata_i[7:0];
    end
  end

  // Zero-latency read mux; same-cycle writes are not forwarded.
  always_comb begin
    data_rdata_o = '0;
    if (ram_hit_c) begin
      data_rdata_o = ram[ram_idx_c];
    end else if (mmio_hit_c) begin
      case (mmio_off_c)
        OFF_CYCLE:    data_rdata_o = cycle_q;
        OFF_CON_TX:   data_rdata_o = '0;
        OFF_CON_STAT: data_rdata_o = {16'd0, 8'(count_q), 5'd0, overflow_q,
                                      fifo_empty_c, fifo_full_c};
        OFF_EXIT:     data_rdata_o = {23'd0, halt_o, exit_code_o};
        default:      data_rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed plus randomized bench for data_bus_responder against a queue/array model.
module tb_data_bus_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_rdata_o;
  logic        con_valid_o;
  logic [7:0]  con_data_o;
  logic        con_ready_i;
  logic        halt_o;
  logic        pass_o;
  logic        fail_o;
  logic [7:0]  exit_code_o;

  data_bus_responder dut (
    .clk(clk), .rst(rst),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_we_i(data_we_i),
    .data_rdata_o(data_rdata_o),
    .con_valid_o(con_valid_o), .con_data_o(con_data_o), .con_ready_i(con_ready_i),
    .halt_o(halt_o), .pass_o(pass_o), .fail_o(fail_o), .exit_code_o(exit_code_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [1024];
  logic [7:0]  q [$];
  bit          m_ovf;
  bit          m_halt;
  logic [7:0]  m_code;
  logic [31:0] tb_cyc;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rd;
  logic [7:0]  last_cd;
  logic        last_cv;
  logic [10:0] last_ex;

  // Expected CYCLE value: posedges seen since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cyc <= 32'd0;
    else      tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == MB[31:4];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = q.size();
    if (a < 32'h1000) return ram_m[a >> 2];
    if (!is_mmio(a)) return 32'd0;
    case (a[3:2])
      2'd0: return tb_cyc;
      2'd2: return {16'd0, 8'(n), 5'd0, m_ovf, (n == 0), (n == 16)};
      2'd3: return {23'd0, m_halt, m_code};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [10:0] model_exit();
    return {m_halt, m_halt && (m_code == 8'd0), m_halt && (m_code != 8'd0), m_code};
  endfunction

  task automatic model_update(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] we, input logic rdy);
    bit full;
    bit push;
    full = (q.size() == 16);
    push = is_mmio(a) && (a[3:2] == 2'd1) && we[0];
    if (a < 32'h1000)
      for (int b = 0; b < 4; b++)
        if (we[b]) ram_m[a >> 2][8*b +: 8] = wd[8*b +: 8];
    if (push && full) m_ovf = 1'b1;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (push && !full) q.push_back(wd[7:0]);
    if (is_mmio(a) && a[3:2] == 2'd3 && we[0] && !m_halt) begin
      m_halt = 1'b1;
      m_code = wd[7:0];
    end
  endtask

  // One bus cycle: drive at negedge, check combinational/state outputs, then clock.
  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input logic rdy);
    @(negedge clk);
    data_addr_i = a; data_wdata_i = wd; data_we_i = we; con_ready_i = rdy;
    #1;
    last_rd = data_rdata_o;
    last_cd = con_data_o;
    last_cv = con_valid_o;
    last_ex = {halt_o, pass_o, fail_o, exit_code_o};
    chk("rdata", data_rdata_o, model_read(a));
    chk("con_valid", 32'(con_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) chk("con_data", 32'(con_data_o), 32'(q[0]));
    chk("exit_state", 32'(last_ex), 32'(model_exit()));
    @(posedge clk);
    model_update(a, wd, we, rdy);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    @(posedge clk);
    data_addr_i = MB; data_we_i = 4'h0; con_ready_i = 1'b0;
    #2 rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_halt = 1'b0; m_code = 8'd0;
    #1;
    chk("rst_con_valid", 32'(con_valid_o), 32'd0);
    chk("rst_cycle", data_rdata_o, 32'd0);
    chk("rst_exit", 32'({halt_o, pass_o, fail_o, exit_code_o}), 32'd0);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] unm [4];
    unm[0] = 32'h0000_4000; unm[1] = 32'h0000_1000;
    unm[2] = MB + 32'h10;   unm[3] = 32'hFFFF_FFFC;
    for (int i = 0; i < 1024; i++) ram_m[i] = 32'd0;
    m_ovf = 1'b0; m_halt = 1'b0; m_code = 8'd0;
    rst = 1'b0; data_addr_i = MB; data_wdata_i = 32'd0; data_we_i = 4'h0; con_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_con_valid", 32'(con_valid_o), 32'd0);
    chk("init_cycle", data_rdata_o, 32'd0);
    chk("init_exit", 32'({halt_o, pass_o, fail_o, exit_code_o}), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Known RAM contents for the randomized window.
    for (int i = 0; i < 64; i++) step(32'(i * 4), 32'd0, 4'hF, 1'b0);

    // RAM byte lanes
    step(32'h100, 32'h1122_3344, 4'hF, 1'b0);
    step(32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0);
    step(32'h100, 32'd0, 4'h0, 1'b0);
    chk("ram_lanes", last_rd, 32'h11BB_33DD);
    step(32'h102, 32'd0, 4'h0, 1'b0);
    chk("ram_unaligned", last_rd, 32'h11BB_33DD);

    // Cycle counter: tenth cycle after release reads 10
    do_reset();
    for (int i = 0; i < 9; i++) step(32'h4000, 32'd0, 4'h0, 1'b0);
    step(MB, 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk("cycle_10", last_rd, 32'd10);

    // Console FIFO basic
    step(MB + 4, 32'h48, 4'h1, 1'b0);
    step(MB + 4, 32'h69, 4'h1, 1'b0);
    step(MB + 8, 32'd0, 4'h0, 1'b0);
    chk("con_stat_2", last_rd, 32'h0000_0200);
    step(32'h4000, 32'd0, 4'h0, 1'b1);
    chk("con_head_48", 32'(last_cd), 32'h48);
    step(32'h4000, 32'd0, 4'h0, 1'b1);
    chk("con_head_69", 32'(last_cd), 32'h69);
    step(MB + 8, 32'd0, 4'h0, 1'b0);
    chk("con_drained_valid", 32'(last_cv), 32'd0);
    chk("con_stat_empty", last_rd, 32'h0000_0002);

    // Overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) step(MB + 4, 32'(i), 4'h1, 1'b0);
    step(MB + 8, 32'd0, 4'h0, 1'b0);
    chk("con_stat_ovf", last_rd, 32'h0000_1005);
    for (int i = 0; i < 16; i++) step(32'h4000, 32'd0, 4'h0, 1'b1);
    chk("con_last_byte", 32'(last_cd), 32'h0F);
    step(32'h4000, 32'd0, 4'h0, 1'b0);
    chk("con_17th_lost", 32'(last_cv), 32'd0);
    for (int i = 0; i < 3; i++) step(MB + 4, 32'(8'hA0 + i), 4'h1, 1'b0);
    step(MB + 4, 32'h77, 4'h1, 1'b1);
    step(MB + 8, 32'd0, 4'h0, 1'b0);
    chk("con_pushpop_cnt3", last_rd, 32'h0000_0304);

    // Exit register
    step(MB + 12, 32'd0, 4'h1, 1'b0);
    step(MB + 12, 32'd5, 4'h1, 1'b0);
    chk("exit_pass", 32'(last_ex), 32'({1'b1, 1'b1, 1'b0, 8'd0}));
    step(MB + 12, 32'd0, 4'h0, 1'b0);
    chk("exit_first_wins", last_rd, 32'h0000_0100);
    do_reset();
    step(MB + 12, 32'd5, 4'h1, 1'b0);
    step(MB + 12, 32'd0, 4'h0, 1'b0);
    chk("exit_fail", 32'(last_ex), 32'({1'b1, 1'b0, 1'b1, 8'd5}));
    chk("exit_read", last_rd, 32'h0000_0105);

    // Async reset with 4 bytes queued; RAM retained
    do_reset();
    for (int i = 0; i < 4; i++) step(MB + 4, 32'(i + 1), 4'h1, 1'b0);
    do_reset();
    step(32'h100, 32'd0, 4'h0, 1'b0);
    chk("ram_retained", last_rd, 32'h11BB_33DD);
    step(32'h4000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("unmapped_4000", last_rd, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int sel;
      if (i == 250) do_reset();
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
      else if (sel < 9) a = MB | {28'd0, 4'($urandom)};
      else              a = unm[$urandom_range(0, 3)];
      step(a, $urandom, 4'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
